// File: rtl/mux_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mux_pkg
// Purpose  : Shared definitions for the mux_scan_nx1 block.
//            - FSM state encoding (IDLE / RUN / DRAIN)
//            - Mode encoding for the mode input / latched mode register
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_comb_nx1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mux_comb_nx1
// Purpose  : Parametrised combinational N-to-1 selector, W bits per channel.
//            An index at or beyond N yields all-zero data.
// Ports    : in   - flat channel bus, channel k at in[k*W +: W]
//            idx  - channel index
//            data - selected channel (zero when idx >= N)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mux_comb_nx1 #(
    parameter int N    = 16,
    parameter int W    = 1,
    parameter int SELW = $clog2(N)
) (
    input  logic [N*W-1:0]  in,
    input  logic [SELW-1:0] idx,
    output logic [W-1:0]    data
);

    logic [W-1:0] w_ch [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_ch
            assign w_ch[g] = in[g*W +: W];
        end
    endgenerate

    // Default of zero covers every index with no matching channel.
    always_comb begin
        data = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == SELW'(k)) begin
                data = w_ch[k];
            end
        end
    end

endmodule : mux_comb_nx1
`default_nettype wire

// File: rtl/mux_scan_nx1.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mux_scan_nx1
// Purpose  : Registered N-to-1 multiplexer with direct (sel-driven) and
//            round-robin scan modes, and a valid/ready output handshake.
// Ports    : clk, rst          - clock (rising edge), async active-high reset
//            in                - flat channel bus, channel k at in[k*W +: W]
//            sel               - direct: channel select; scan: start channel
//            mode              - 0 direct, 1 scan (latched when leaving IDLE)
//            en                - run request
//            out_data/out_ch   - registered sample and its channel index
//            out_last          - scan mode, sample came from channel N-1
//            out_valid/out_ready - output handshake
//            busy              - FSM not in IDLE
//            sel_err           - sticky out-of-range select flag (optional)
// Config   : define MUX_SCAN_SEL_CHK_EN to add the sel_err output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int N    = 16,
    parameter int W    = 1,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef MUX_SCAN_SEL_CHK_EN
    output logic            sel_err,
`endif
    output logic            busy
);

    localparam logic [SELW-1:0] c_last  = SELW'(N - 1);
    localparam logic [SELW:0]   c_n_ext = (SELW + 1)'(N);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SELW-1:0] r_cnt;
    logic            r_mode;
    logic [W-1:0]    r_out_data;
    logic [SELW-1:0] r_out_ch;
    logic            r_out_last;
    logic            r_out_valid;

    logic            w_load;
    logic            w_xfer;
    logic            w_start;
    logic            w_sel_oor;
    logic [SELW-1:0] w_idx;
    logic [W-1:0]    w_data;

    assign w_xfer    = r_out_valid && out_ready;
    assign w_load    = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_start   = (r_state == IDLE) && en;
    assign w_sel_oor = ({1'b0, sel} >= c_n_ext);

    // Scan counter is clamped on entry, so it is always a valid channel.
    assign w_idx = (r_mode == MODE_SCAN) ? r_cnt : sel;

    mux_comb_nx1 #(
        .N    (N),
        .W    (W),
        .SELW (SELW)
    ) u_sel (
        .in   (in),
        .idx  (w_idx),
        .data (w_data)
    );

    //--------------------------------------------------------------------------
    // FSM next state
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) w_state_nxt = RUN;
            end
            RUN: begin
                if (!en) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                // A re-request wins; otherwise leave only once the held
                // sample has gone (or is going) to the consumer.
                if (en)                           w_state_nxt = RUN;
                else if (!r_out_valid || w_xfer)  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // State, mode, scan counter and output register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE_DIRECT;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start) begin
                r_mode <= mode;
                r_cnt  <= w_sel_oor ? '0 : sel;
            end

            if (w_load) begin
                r_out_data  <= w_data;
                r_out_ch    <= w_idx;
                r_out_last  <= (r_mode == MODE_SCAN) && (r_cnt == c_last);
                r_out_valid <= 1'b1;
                // Counter only moves on a load, so backpressure stalls the scan.
                if (r_mode == MODE_SCAN) begin
                    r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                end
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_SCAN_SEL_CHK_EN
    logic r_sel_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_sel_oor &&
                     (w_start || (w_load && (r_mode == MODE_DIRECT)))) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`endif

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);

endmodule : mux_scan_nx1
`default_nettype wire

// File: tb/tb_mux_scan_nx1.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_mux_scan_nx1
// Purpose  : Self-checking bench for mux_scan_nx1. Three instances:
//            A (N=16,W=8) direct mode, B (N=5,W=4) scan / backpressure /
//            drain / reset, C (N=12,W=4) out-of-range select.
//            Instance B transfers are checked against a queue of expected
//            samples filled when each stimulus phase is driven.
// Config   : MUX_SCAN_SEL_CHK_EN adds sel_err connections and checks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mux_scan_nx1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A
    logic [16*8-1:0] a_in;
    logic [3:0]      a_sel;
    logic            a_mode, a_en, a_ready;
    logic [7:0]      a_data;
    logic [3:0]      a_ch;
    logic            a_last, a_valid, a_busy;
    // Instance B
    logic [5*4-1:0]  b_in;
    logic [2:0]      b_sel;
    logic            b_mode, b_en, b_ready;
    logic [3:0]      b_data;
    logic [2:0]      b_ch;
    logic            b_last, b_valid, b_busy;
    // Instance C
    logic [12*4-1:0] c_in;
    logic [3:0]      c_sel;
    logic            c_mode, c_en, c_ready;
    logic [3:0]      c_data;
    logic [3:0]      c_ch;
    logic            c_last, c_valid, c_busy;
`ifdef MUX_SCAN_SEL_CHK_EN
    logic            a_err, b_err, c_err;
`endif

    mux_scan_nx1 #(.N(16), .W(8)) u_a (
        .clk(clk), .rst(rst), .in(a_in), .sel(a_sel), .mode(a_mode), .en(a_en),
        .out_data(a_data), .out_ch(a_ch), .out_last(a_last), .out_valid(a_valid),
        .out_ready(a_ready),
`ifdef MUX_SCAN_SEL_CHK_EN
        .sel_err(a_err),
`endif
        .busy(a_busy)
    );

    mux_scan_nx1 #(.N(5), .W(4)) u_b (
        .clk(clk), .rst(rst), .in(b_in), .sel(b_sel), .mode(b_mode), .en(b_en),
        .out_data(b_data), .out_ch(b_ch), .out_last(b_last), .out_valid(b_valid),
        .out_ready(b_ready),
`ifdef MUX_SCAN_SEL_CHK_EN
        .sel_err(b_err),
`endif
        .busy(b_busy)
    );

    mux_scan_nx1 #(.N(12), .W(4)) u_c (
        .clk(clk), .rst(rst), .in(c_in), .sel(c_sel), .mode(c_mode), .en(c_en),
        .out_data(c_data), .out_ch(c_ch), .out_last(c_last), .out_valid(c_valid),
        .out_ready(c_ready),
`ifdef MUX_SCAN_SEL_CHK_EN
        .sel_err(c_err),
`endif
        .busy(c_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel contents of instance B: 1,4,7,10,13
    function automatic logic [3:0] bdat(input int k);
        return 4'(k * 3 + 1);
    endfunction

    // Expected B transfers: {last, ch, data}
    logic [7:0] sb_q[$];

    task automatic push_b(input int k);
        sb_q.push_back({(k == 4), 3'(k), bdat(k)});
    endtask

    always @(negedge clk) begin
        if (!rst && b_valid && b_ready) begin
            if (sb_q.size() == 0) begin
                check("b_sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                check("b_xfer", 32'({b_last, b_ch, b_data}), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic wait_b_idle(input string tag);
        for (int i = 0; i < 20 && b_busy; i++) tick();
        check(tag, 32'(b_busy), 32'd0);
        check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) a_in[k*8 +: 8] = 8'(k + 16);
        for (int k = 0; k < 5;  k++) b_in[k*4 +: 4] = bdat(k);
        for (int k = 0; k < 12; k++) c_in[k*4 +: 4] = 4'(k + 1);
        rst = 1'b1;
        a_sel = '0; a_mode = 1'b0; a_en = 1'b0; a_ready = 1'b0;
        b_sel = '0; b_mode = 1'b0; b_en = 1'b0; b_ready = 1'b0;
        c_sel = '0; c_mode = 1'b0; c_en = 1'b0; c_ready = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_data",  32'(a_data),  32'd0);
        check("rst_a_busy",  32'(a_busy),  32'd0);
        check("rst_b_out",   32'({b_last, b_ch, b_data, b_valid, b_busy}), 32'd0);
        check("rst_c_out",   32'({c_last, c_ch, c_data, c_valid, c_busy}), 32'd0);
`ifdef MUX_SCAN_SEL_CHK_EN
        check("rst_c_err",   32'(c_err), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // ---- A: direct mode latency and sel change ----
        a_sel = 4'd5; a_mode = 1'b0; a_ready = 1'b1; a_en = 1'b1;
        tick();
        check("a_lat_valid0", 32'(a_valid), 32'd0);
        check("a_busy_run",   32'(a_busy),  32'd1);
        tick();
        check("a_first_valid", 32'(a_valid), 32'd1);
        check("a_first_data",  32'(a_data),  32'h15);
        check("a_first_ch",    32'(a_ch),    32'd5);
        check("a_first_last",  32'(a_last),  32'd0);
        a_sel = 4'd9;
        tick();
        check("a_sel9_data", 32'(a_data), 32'h19);
        check("a_sel9_ch",   32'(a_ch),   32'd9);
        a_en = 1'b0;
        tick();
        tick();
        check("a_idle_valid", 32'(a_valid), 32'd0);
        check("a_idle_busy",  32'(a_busy),  32'd0);

        // ---- B: scan from 3, mode/sel changes mid-run ignored ----
        b_sel = 3'd3; b_mode = 1'b1; b_ready = 1'b1; b_en = 1'b1;
        push_b(3); push_b(4); push_b(0); push_b(1); push_b(2); push_b(3);
        tick(); tick(); tick();
        b_mode = 1'b0; b_sel = 3'd0;
        tick(); tick(); tick();
        b_en = 1'b0;
        wait_b_idle("b_scan_idle");

        // ---- B: backpressure holds channel 0, no skip after release ----
        b_sel = 3'd0; b_mode = 1'b1; b_ready = 1'b0; b_en = 1'b1;
        push_b(0); push_b(1); push_b(2); push_b(3);
        tick();
        tick();
        check("b_bp_valid", 32'(b_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_bp_hold", 32'({b_valid, b_ch, b_data}), 32'({1'b1, 3'd0, bdat(0)}));
        end
        b_ready = 1'b1;
        tick();
        tick();
        b_en = 1'b0;
        wait_b_idle("b_bp_idle");

        // ---- B: en dropped with a held sample -> DRAIN ----
        b_sel = 3'd2; b_mode = 1'b1; b_ready = 1'b0; b_en = 1'b1;
        push_b(2);
        tick();
        tick();
        check("b_dr_ch", 32'({b_valid, b_ch}), 32'({1'b1, 3'd2}));
        b_en = 1'b0;
        tick();
        check("b_dr_busy", 32'({b_busy, b_valid, b_ch}), 32'({1'b1, 1'b1, 3'd2}));
        tick();
        check("b_dr_busy2", 32'({b_busy, b_valid}), 32'({1'b1, 1'b1}));
        b_ready = 1'b1;
        tick();
        check("b_dr_done", 32'({b_busy, b_valid}), 32'd0);
        check("b_dr_sb_left", 32'(sb_q.size()), 32'd0);

        // ---- C: out-of-range direct select ----
        c_sel = 4'd14; c_mode = 1'b0; c_ready = 1'b1; c_en = 1'b1;
        tick();
`ifdef MUX_SCAN_SEL_CHK_EN
        check("c_err_start", 32'(c_err), 32'd1);
`endif
        tick();
        check("c_oor_out", 32'({c_valid, c_ch, c_data}), 32'({1'b1, 4'd14, 4'd0}));
        c_sel = 4'd3;
        tick();
        check("c_inr_out", 32'({c_valid, c_ch, c_data}), 32'({1'b1, 4'd3, 4'd4}));
        c_en = 1'b0;
        tick(); tick(); tick();
        check("c_idle_busy", 32'(c_busy), 32'd0);
`ifdef MUX_SCAN_SEL_CHK_EN
        check("c_err_sticky", 32'(c_err), 32'd1);
`endif
        // Scan start beyond N clamps to channel 0
        c_sel = 4'd13; c_mode = 1'b1; c_en = 1'b1;
        tick();
        tick();
        check("c_clamp_out", 32'({c_valid, c_ch, c_data, c_last}), 32'({1'b1, 4'd0, 4'd1, 1'b0}));
        c_en = 1'b0;
        tick(); tick(); tick();
        check("c_clamp_idle", 32'(c_busy), 32'd0);

        // ---- B: async reset mid-scan, then restart from sel ----
        b_sel = 3'd1; b_mode = 1'b1; b_ready = 1'b0; b_en = 1'b1;
        tick();
        tick();
        check("b_pre_rst", 32'({b_valid, b_ch}), 32'({1'b1, 3'd1}));
        #2 rst = 1'b1;
        #1;
        check("b_async_rst", 32'({b_last, b_ch, b_data, b_valid, b_busy}), 32'd0);
`ifdef MUX_SCAN_SEL_CHK_EN
        check("c_err_cleared", 32'(c_err), 32'd0);
`endif
        rst = 1'b0;
        b_ready = 1'b1;
        push_b(1); push_b(2);
        tick();
        tick();
        check("b_restart", 32'({b_valid, b_ch}), 32'({1'b1, 3'd1}));
        b_en = 1'b0;
        wait_b_idle("b_restart_idle");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux_scan_nx1
`default_nettype wire
